// File: rtl/t_msg_sequencer.sv
// Message sequencer: walks the 13-way byte mux select from 0 to MSG_LEN-1,
// registers each selected byte and hands it to the serial transmitter.
module t_msg_sequencer #(
  parameter int MSG_LEN = 13,
  parameter int SEL_W   = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_y,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshake: a byte transfers at a rising edge where tx_valid && tx_ready;
  // once raised, tx_valid stays high and tx_data stays stable until that edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(MSG_LEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_tx_data_nxt;
  logic              r_tx_valid;
  logic              w_tx_valid_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    case (r_state)
      IDLE: begin
        w_sel_nxt      = '0;
        w_tx_valid_nxt = 1'b0;
        if (start) w_state_nxt = FETCH;
      end
      FETCH: begin
        w_tx_data_nxt  = mux_y;
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          if (r_sel == LAST_SEL) begin
            w_state_nxt = DONE;
          end else begin
            w_sel_nxt   = r_sel + SEL_W'(1);
            w_state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        w_sel_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort wins over a same-cycle handshake: that byte is treated as unsent.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt    = IDLE;
      w_sel_nxt      = '0;
      w_tx_valid_nxt = 1'b0;
    end
  end

  assign sel       = r_sel;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_t_msg_sequencer.sv
// Directed bench for t_msg_sequencer with a behavioural 13-way mux (xN = 8'h30+N).
module tb_t_msg_sequencer;

  localparam int MSG_LEN = 13;
  localparam int SEL_W   = 4;
  localparam int DATA_W  = 8;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_y;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int k_edge = 0;
  int done_cnt = 0;
  int done_edge = 0;
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                acc_q[$];

  t_msg_sequencer #(.MSG_LEN(MSG_LEN), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .sel(sel),
    .mux_y(mux_y), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Mux model: input xN carries 8'h30 + N.
  assign mux_y = 8'h30 + {{(DATA_W-SEL_W){1'b0}}, sel};

  // Clock and edge counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  // Monitor: samples just before each rising edge; edge numbers are the upcoming edge.
  always @(negedge clk) begin
    #4;
    if (reset_n) begin
      if (start && dbg_state == 2'd0) k_edge = cyc + 1;
      if (tx_valid && tx_ready && !abort) begin
        got_q.push_back(tx_data);
        acc_q.push_back(cyc + 1);
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    got_q.delete();
    acc_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_byte(input string tag, input logic [DATA_W-1:0] b);
    for (int n = 0; n < 200 && !(tx_valid && tx_data == b); n++) @(negedge clk);
    check({tag, "_wait"}, {tx_valid, tx_data}, {1'b1, b});
  endtask

  // Compare captured bytes with the expected queue and the done pulse count.
  task automatic check_msg(input string tag, input int n_bytes, input int n_done);
    for (int i = 0; i < n_bytes; i++) exp_q.push_back(DATA_W'(8'h30 + i));
    check({tag, "_count"}, got_q.size(), n_bytes);
    for (int i = 0; i < n_bytes && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_done_cnt"}, done_cnt, n_done);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    tx_ready = 1'b1;

    // Reset held 3 cycles with start high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d", i), {sel, tx_data, tx_valid, busy, done},
            {4'd0, 8'd0, 1'b0, 1'b0, 1'b0});
    end
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_release_idle", {busy, dbg_state}, {1'b0, 2'd0});

    // Full message with tx_ready held high, timing checked per byte
    clear_sb();
    pulse_start();
    check("full_fetch", dbg_state, 2'd1);
    wait_idle("full");
    check_msg("full", MSG_LEN, 1);
    for (int i = 0; i < MSG_LEN && i < acc_q.size(); i++)
      check($sformatf("full_edge%0d", i), acc_q[i], k_edge + 2 + 2 * i);
    check("full_done_edge", done_edge, k_edge + 27);
    check("full_sel_end", sel, 4'd0);

    // Backpressure on byte 3
    clear_sb();
    pulse_start();
    wait_byte("bp", 8'h33);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {tx_valid, tx_data}, {1'b1, 8'h33});
    end
    tx_ready = 1'b1;
    wait_idle("bp");
    check_msg("bp", MSG_LEN, 1);

    // start while busy is ignored
    clear_sb();
    pulse_start();
    wait_byte("sb", 8'h36);
    pulse_start();
    wait_idle("sb");
    @(negedge clk);
    @(negedge clk);
    check("sb_no_restart", busy, 1'b0);
    check_msg("sb", MSG_LEN, 1);

    // Abort coincident with the byte 8 handshake
    clear_sb();
    pulse_start();
    wait_byte("ab", 8'h38);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_state", {dbg_state, sel, tx_valid, busy}, {2'd0, 4'd0, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    check_msg("ab", 8, 0);
    clear_sb();
    pulse_start();
    wait_idle("ab_new");
    check_msg("ab_new", MSG_LEN, 1);

    // Reset during byte 10 SEND
    clear_sb();
    pulse_start();
    wait_byte("mr", 8'h3A);
    reset_n = 1'b0;
    @(negedge clk);
    check("mr_outputs", {sel, tx_data, tx_valid, busy, done},
          {4'd0, 8'd0, 1'b0, 1'b0, 1'b0});
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_busy", busy, 1'b0);
    check("mr_done_cnt", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t_msg_sequencer.md
Name: t_msg_sequencer

Overview:
- Upstream/downstream companion of the 13-way 8-bit message mux.
- Drives the mux `sel` from 0 through MSG_LEN-1 and registers each selected byte.
- Hands each byte to the serial transmitter over a valid/ready handshake.
- One `start` sends the whole message once, in index order, then pulses `done`.

Parameters:
- MSG_LEN, 13, number of bytes per message (mux inputs x0..x12); must be 1..2**SEL_W.
- SEL_W, 4, width of the mux select.
- DATA_W, 8, byte width of mux output and tx data.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  level; sampled only in IDLE; high begins a message.
- abort  input  1  synchronous; high in any non-IDLE state cancels the message.
- sel  output  SEL_W  select driven to the mux.
- mux_y  input  DATA_W  mux output for the current sel (combinational path through mux).
- tx_data  output  DATA_W  registered byte presented to transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts when tx_valid && tx_ready at a rising edge.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, sel=0, tx_data=0, tx_valid=0, busy=0, done=0. Reset overrides start, abort and handshake.
- States and transitions:
  - IDLE: sel=0, tx_valid=0. start=1 -> FETCH.
  - FETCH: one cycle; mux settles on sel. At the edge: tx_data<=mux_y, tx_valid<=1 -> SEND.
  - SEND: tx_data and tx_valid held stable until the handshake.
  - SEND, on handshake: tx_valid<=0. If sel==MSG_LEN-1 -> DONE, else sel<=sel+1 -> FETCH.
  - DONE: done=1 for exactly this cycle; sel<=0 -> IDLE.
- Timing:
  - Start sampled at edge k: tx_valid rises after edge k+1.
  - With tx_ready held 1, byte i is accepted at edge k+2+2i.
  - For MSG_LEN=13, the last accept is at edge k+26; done is high between edges k+26 and k+27; IDLE from k+27.
  - Minimum byte period: 2 cycles.
- Backpressure: tx_ready low holds the state; tx_data must not change and tx_valid must not drop while waiting. tx_ready is ignored when tx_valid=0.
- start while busy: ignored, no restart, no queuing. start still high in IDLE after DONE begins a new message immediately.
- abort: in FETCH/SEND/DONE, next state IDLE, sel=0, tx_valid=0, no done pulse. abort in IDLE has no effect. abort has priority over a simultaneous handshake; that byte counts as not sent.
- sel never exceeds MSG_LEN-1; no wrap during a message. Out-of-range mux codes are never driven.
- MSG_LEN=1: FETCH, SEND, DONE with sel fixed at 0.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 -> sel=0, tx_valid=0, busy=0, done=0 throughout; after release, first FETCH at the next sampled start.
- Full message: mux model xN=8'h30+N, tx_ready=1, 1-cycle start pulse -> 13 accepted bytes 8'h30..8'h3C in order, one every 2 cycles, done pulse at edge k+26..k+27, then busy=0.
- Backpressure: drop tx_ready for 5 cycles while byte 3 is valid -> tx_data=8'h33 and tx_valid=1 stable for all 5 cycles; stream resumes with 8'h34; still exactly 13 bytes.
- start while busy: re-pulse start at byte 6 -> ignored; exactly 13 bytes and one done pulse.
- Abort: assert abort in the same cycle as the byte 8 handshake -> IDLE next cycle, sel=0, tx_valid=0, no done; a new start sends from 8'h30.
- Reset mid-message: reset_n=0 during byte 10 SEND -> all outputs at reset values next cycle; no done pulse.
